// File: rtl/seq_pkg.sv
// Shared definitions for the serial 1101 transmitter and the sequence detectors.
// Holds the FSM state encoding, the reference pattern and a burst-length helper.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam logic [3:0] SEQ_1101 = 4'b1101;

    // Cycles for which busy is high in a burst of r repetitions.
    function automatic int busy_cycles(input int r, input int pat_w, input int gap);
        if (r <= 0) begin
            return 0;
        end
        return r * pat_w + (r - 1) * gap;
    endfunction

endpackage

// File: rtl/seq_1101_tx.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first, repeat_cnt times,
// with optional zero gaps between repetitions. All outputs are registered.
module seq_1101_tx
    import seq_pkg::*;
#(
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = SEQ_1101,
    parameter int                CNT_W   = 4,
    parameter int                GAP     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W = 4;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    seq_state_e       state_reg,    state_next;
    logic [IDX_W-1:0] bit_idx_reg,  bit_idx_next;
    logic [CNT_W-1:0] rep_left_reg, rep_left_next;
    logic [GAP_W-1:0] gap_cnt_reg,  gap_cnt_next;
    logic             x_reg,        x_next;
    logic             valid_reg,    valid_next;
    logic             busy_reg,     busy_next;
    logic             done_reg,     done_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            bit_idx_reg  <= '0;
            rep_left_reg <= '0;
            gap_cnt_reg  <= '0;
            x_reg        <= 1'b0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_idx_reg  <= bit_idx_next;
            rep_left_reg <= rep_left_next;
            gap_cnt_reg  <= gap_cnt_next;
            x_reg        <= x_next;
            valid_reg    <= valid_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_idx_next  = bit_idx_reg;
        rep_left_next = rep_left_reg;
        gap_cnt_next  = gap_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    rep_left_next = repeat_cnt;
                    bit_idx_next  = IDX_TOP;
                    state_next    = (repeat_cnt == '0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (bit_idx_reg != '0) begin
                    bit_idx_next = bit_idx_reg - 1'b1;
                end else if (rep_left_reg > CNT_W'(1)) begin
                    rep_left_next = rep_left_reg - 1'b1;
                    bit_idx_next  = IDX_TOP;
                    if (GAP > 0) begin
                        // Gap counter counts down to zero, giving exactly GAP idle cycles.
                        gap_cnt_next = GAP_W'(GAP - 1);
                        state_next   = ST_GAP;
                    end else begin
                        state_next   = ST_SEND;
                    end
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == '0) begin
                    bit_idx_next = IDX_TOP;
                    state_next   = ST_SEND;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register alongside it.
        valid_next = (state_next == ST_SEND);
        x_next     = valid_next ? PATTERN[bit_idx_next] : 1'b0;
        busy_next  = (state_next == ST_SEND) || (state_next == ST_GAP);
        done_next  = (state_next == ST_DONE);
    end

    assign x     = x_reg;
    assign valid = valid_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_seq_1101_tx.sv
// Self-checking bench for seq_1101_tx: a GAP=0 and a GAP=2 instance share stimulus
// and are compared every cycle against per-burst expected output tables.
module tb_seq_1101_tx;
    import seq_pkg::*;

    typedef logic [3:0] ent_t;      // {x, valid, busy, done}
    typedef ent_t ent_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] repeat_cnt = '0;

    logic x0, valid0, busy0, done0;
    logic x2, valid2, busy2, done2;

    int n_checks = 0;
    int n_errors = 0;

    ent_q_t q0;
    ent_q_t q2;

    always #5 clk = ~clk;

    seq_1101_tx #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(4), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .repeat_cnt(repeat_cnt),
        .x(x0), .valid(valid0), .busy(busy0), .done(done0)
    );

    seq_1101_tx #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(4), .GAP(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .repeat_cnt(repeat_cnt),
        .x(x2), .valid(valid2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected per-cycle output table for one burst, built from the pattern rules.
    function automatic ent_q_t burst(input int r, input int gap);
        ent_q_t q;
        logic [3:0] pat;
        pat = SEQ_1101;
        q = {};
        for (int rep = 0; rep < r; rep++) begin
            for (int b = 3; b >= 0; b--) begin
                q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
            end
            if (rep < r - 1) begin
                for (int g = 0; g < gap; g++) begin
                    q.push_back(4'b0010);
                end
            end
        end
        q.push_back(4'b0001);
        return q;
    endfunction

    task automatic model_edge(input logic s, input logic [3:0] rc);
        if (q0.size() > 0) begin
            void'(q0.pop_front());
        end else if (s) begin
            q0 = burst(int'(rc), 0);
            $display("burst gap=0 rep=%0d t=%0t", rc, $time);
        end
        if (q2.size() > 0) begin
            void'(q2.pop_front());
        end else if (s) begin
            q2 = burst(int'(rc), 2);
            $display("burst gap=2 rep=%0d t=%0t", rc, $time);
        end
    endtask

    task automatic compare();
        ent_t e0;
        ent_t e2;
        e0 = (q0.size() > 0) ? q0[0] : 4'b0000;
        e2 = (q2.size() > 0) ? q2[0] : 4'b0000;
        check("gap0_outs", {28'd0, x0, valid0, busy0, done0}, {28'd0, e0});
        check("gap2_outs", {28'd0, x2, valid2, busy2, done2}, {28'd0, e2});
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic s, input logic [3:0] rc);
        start = s;
        repeat_cnt = rc;
        @(posedge clk);
        model_edge(s, rc);
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0;
        #1;
        q0.delete();
        q2.delete();
        check({tag, "_gap0"}, {28'd0, x0, valid0, busy0, done0}, 32'd0);
        check({tag, "_gap2"}, {28'd0, x2, valid2, busy2, done2}, 32'd0);
        rst = 1'b1;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'd0);
        end
    endtask

    initial begin
        logic [11:0] xs12;
        logic [9:0]  xs10;
        logic [9:0]  vs10;
        int bz;
        int nv;

        // Reset takes effect with no clock edge, start held high.
        start = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check("reset_gap0", {28'd0, x0, valid0, busy0, done0}, 32'd0);
        check("reset_gap2", {28'd0, x2, valid2, busy2, done2}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        step(1'b0, 4'd0);

        // Single burst on both instances.
        step(1'b1, 4'd1);
        drain();

        // Back-to-back repetitions with no gap.
        step(1'b1, 4'd3);
        xs12 = '0;
        bz = 0;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            xs12 = {xs12[10:0], x0};
            bz += int'(busy0);
            nv += int'(valid0);
            step(1'b0, 4'd0);
        end
        check("b2b_bits", {20'd0, xs12}, 32'h0000_0DDD);
        check("b2b_busy", bz, busy_cycles(3, 4, 0));
        check("b2b_valid", nv, 12);
        check("b2b_done", {31'd0, done0}, 32'd1);
        drain();

        // Gap insertion on the GAP=2 instance.
        step(1'b1, 4'd2);
        xs10 = '0;
        vs10 = '0;
        bz = 0;
        for (int i = 0; i < 10; i++) begin
            xs10 = {xs10[8:0], x2};
            vs10 = {vs10[8:0], valid2};
            bz += int'(busy2);
            step(1'b0, 4'd0);
        end
        check("gap_bits", {22'd0, xs10}, {22'd0, 10'b1101001101});
        check("gap_valid", {22'd0, vs10}, {22'd0, 10'b1111001111});
        check("gap_busy", bz, busy_cycles(2, 4, 2));
        check("gap_done", {31'd0, done2}, 32'd1);
        drain();

        // Zero count: done right away, no bits.
        step(1'b1, 4'd0);
        check("zero_done", {30'd0, done0, valid0}, 32'd2);
        drain();

        // Start pulsed again mid-burst is ignored.
        step(1'b1, 4'd2);
        nv = int'(valid0);
        for (int i = 0; i < 12; i++) begin
            step((i == 3) ? 1'b1 : 1'b0, 4'd9);
            nv += int'(valid0);
        end
        check("ignored_start_bits", nv, 8);
        drain();

        // Abort after the second bit, then a fresh burst from the MSB.
        step(1'b1, 4'd3);
        step(1'b0, 4'd0);
        async_reset("abort");
        bz = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'd0);
            bz += int'(done0) + int'(done2);
        end
        check("abort_no_done", bz, 0);
        step(1'b1, 4'd1);
        xs12 = '0;
        for (int i = 0; i < 4; i++) begin
            xs12 = {xs12[10:0], x0};
            step(1'b0, 4'd0);
        end
        check("abort_fresh_bits", {20'd0, xs12}, 32'h0000_000D);
        drain();

        // Start held high: bursts separated by a single idle cycle.
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 4'd1);
        end
        step(1'b1, 4'd15);
        drain();
        drain();
        drain();

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rand_reset");
            end
            step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_1101_tx.md
Name: seq_1101_tx

Overview:
Serial pattern transmitter: the driving end of the serial-bit interface consumed by the Moore sequence detectors. On a start request it shifts a fixed PAT_W-bit pattern (default 1101) out MSB-first on x, one bit per clock. It repeats the pattern a programmable number of times, with optional idle-zero gaps between repetitions. It stimulates and self-checks the detector blocks, and drives framed patterns onto serial links.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
PATTERN, 4'b1101, pattern shifted out MSB-first
CNT_W, 4, width of repeat_cnt
GAP, 0, zero-bit idle cycles inserted between consecutive repetitions (0..15)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
start  input  1  transmit request, sampled only in IDLE
repeat_cnt  input  CNT_W  number of pattern repetitions, latched at accepted start
x  output  1  serial data bit (0 when valid=0)
valid  output  1  x carries a pattern bit this cycle
busy  output  1  transmission in progress (SEND or GAP)
done  output  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- One clock; reset is asynchronous and active-low: rst=0 immediately forces state=IDLE, x=0, valid=0, busy=0, done=0, and clears all counters, whatever the clock is doing.
- All outputs are registered (Moore). No combinational path from inputs to outputs.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE: if start=1 at an edge, latch repeat_cnt into rep_left.
  - If repeat_cnt=0, go to DONE: no bits sent, done pulses next cycle.
  - Otherwise go to SEND with bit_idx=PAT_W-1. x=PATTERN[PAT_W-1] and valid=1 are visible right after that edge, so latency from the start edge to the first bit is zero extra cycles.
- SEND: each edge decrements bit_idx and drives x=PATTERN[bit_idx]. After the bit_idx=0 bit has been driven:
  - If rep_left>1: decrement rep_left. Go to GAP if GAP>0, otherwise back to SEND at bit PAT_W-1 with no bubble (back-to-back patterns).
  - If rep_left=1: go to DONE.
- GAP: x=0, valid=0, busy=1 for exactly GAP cycles, then SEND at bit PAT_W-1.
- DONE: done=1, busy=0, valid=0 for exactly one cycle, then IDLE. start in DONE is ignored.
- start while busy or in DONE is ignored. repeat_cnt changes after acceptance have no effect.
- Busy duration for R>0 repetitions: R*PAT_W + (R-1)*GAP cycles. done is high on the following cycle.
- Counter widths: bit_idx is ceil(log2(PAT_W)) bits and rep_left is CNT_W bits, with no wrap. The maximum repeat_cnt=2^CNT_W-1 completes correctly.
- Reset asserted mid-transmission aborts immediately. No done pulse. After release the block sits in IDLE until a new start.
- start held high continuously: a new transmission begins on the first IDLE edge after each DONE cycle, giving exactly one idle cycle between bursts.

Decomposition:
- Shared package seq_pkg holds:
  - the FSM state enum (IDLE, SEND, GAP, DONE), also used by the detector FSMs
  - the constant SEQ_1101 = 4'b1101
  - a function returning the busy-cycle count for given R, PAT_W and GAP, used by benches
- No sub-module. The bit and repetition counters live inline with the FSM.

Test Plan:
- Reset check: rst=0 mid-cycle with start=1 -> x=0, valid=0, busy=0 and done=0 immediately, with no clock edge required.
- Single burst, GAP=0, repeat_cnt=1, start pulsed one cycle -> x=1,1,0,1 with valid=1 for 4 cycles, busy=1 for 4 cycles, done=1 on cycle 5, then IDLE.
- Back-to-back, GAP=0, repeat_cnt=3 -> x=110111011101 over 12 contiguous cycles, done on cycle 13. A non-overlapping 1101 detector on x produces exactly 3 z pulses.
- Gap insertion, GAP=2, repeat_cnt=2 -> x/valid sequence 1101 (v=1), 00 (v=0), 1101 (v=1). busy=10 cycles, done on cycle 11.
- Zero count and ignored start: repeat_cnt=0 -> no valid bits, done on the next cycle. In a repeat_cnt=2 burst, pulse start again mid-burst -> still exactly 8 pattern bits.
- Abort: rst=0 after the second bit of a repeat_cnt=3 burst -> outputs clear immediately and no done pulse. A new start after release sends a full fresh 1101 starting from the MSB.
